// File: rtl/reset_sequencer.sv
// reset_sequencer: orders reset release for the mixed-signal datapath
// (ADC clock generator -> DSP -> core) with programmable hold times,
// waits for ADC clock-ready with a timeout, then supervises ADC lock.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ADC_HOLD  | all resets asserted, counting the ADC hold time
// LOCK_WAIT | ADC released, waiting for adc_ready (optional timeout)
// DSP_HOLD  | ADC running, DSP and core still in reset, counting
// CORE_HOLD | DSP released, core still in reset, counting
// RUN       | all resets released, done asserted, lock supervised
// FAIL      | sticky failure, all resets asserted, fail_code valid
module reset_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset_req,
  input  logic [CNT_W-1:0] cfg_adc_dly,
  input  logic [CNT_W-1:0] cfg_dsp_dly,
  input  logic [CNT_W-1:0] cfg_core_dly,
  input  logic [CNT_W-1:0] cfg_lock_timeout,
  input  logic             adc_ready,
  output logic             adc_reset_out,
  output logic             dsp_reset_out,
  output logic             core_reset_out,
  output logic             done,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    ADC_HOLD  = 3'd0,
    LOCK_WAIT = 3'd1,
    DSP_HOLD  = 3'd2,
    CORE_HOLD = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_LOST    = 2'b10;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // first_cycle marks the first cycle spent in a state; the counter is
  // (re)loaded from the config input in that cycle, so later config
  // changes are ignored until the next entry.
  logic             first_cycle, first_nxt;
  logic [1:0]       fail_code_nxt;
  logic [CNT_W-1:0] hold_cfg, hold_cnt, lock_cnt;

  // Select this stage's hold length; a zero delay still lasts one cycle.
  always_comb begin
    hold_cfg = cfg_adc_dly;
    case (state)
      DSP_HOLD:  hold_cfg = cfg_dsp_dly;
      CORE_HOLD: hold_cfg = cfg_core_dly;
      default:   hold_cfg = cfg_adc_dly;
    endcase
    if (hold_cfg == '0) hold_cfg = CNT_W'(1);
    hold_cnt = first_cycle ? hold_cfg : cnt;
    lock_cnt = first_cycle ? cfg_lock_timeout : cnt;
  end

  // Next-state logic: soft reset, then lock loss/timeout, then expiry/ready.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    first_nxt     = 1'b0;
    fail_code_nxt = fail_code;
    case (state)
      ADC_HOLD: begin
        if (hold_cnt == CNT_W'(1)) begin
          state_nxt = LOCK_WAIT;
          first_nxt = 1'b1;
        end else begin
          cnt_nxt = hold_cnt - CNT_W'(1);
        end
      end
      LOCK_WAIT: begin
        // A zero timeout leaves the count parked at 0: wait forever.
        if (adc_ready) begin
          state_nxt = DSP_HOLD;
          first_nxt = 1'b1;
        end else if (lock_cnt == CNT_W'(1)) begin
          state_nxt     = FAIL;
          fail_code_nxt = CODE_TIMEOUT;
        end else if (lock_cnt != '0) begin
          cnt_nxt = lock_cnt - CNT_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      DSP_HOLD, CORE_HOLD: begin
        if (!adc_ready) begin
          state_nxt     = FAIL;
          fail_code_nxt = CODE_LOST;
        end else if (hold_cnt == CNT_W'(1)) begin
          state_nxt = (state == DSP_HOLD) ? CORE_HOLD : RUN;
          first_nxt = 1'b1;
        end else begin
          cnt_nxt = hold_cnt - CNT_W'(1);
        end
      end
      RUN: begin
        if (!adc_ready) begin
          state_nxt     = FAIL;
          fail_code_nxt = CODE_LOST;
        end
      end
      FAIL: state_nxt = FAIL;
      default: begin
        state_nxt = ADC_HOLD;
        first_nxt = 1'b1;
      end
    endcase
    if (soft_reset_req) begin
      state_nxt     = ADC_HOLD;
      first_nxt     = 1'b1;
      cnt_nxt       = '0;
      fail_code_nxt = CODE_NONE;
    end
  end

  // State, counter and failure code registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ADC_HOLD;
      cnt         <= '0;
      first_cycle <= 1'b1;
      fail_code   <= CODE_NONE;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      first_cycle <= first_nxt;
      fail_code   <= fail_code_nxt;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    adc_reset_out  = 1'b1;
    dsp_reset_out  = 1'b1;
    core_reset_out = 1'b1;
    done           = 1'b0;
    fail           = 1'b0;
    case (state)
      LOCK_WAIT, DSP_HOLD: adc_reset_out = 1'b0;
      CORE_HOLD: begin
        adc_reset_out = 1'b0;
        dsp_reset_out = 1'b0;
      end
      RUN: begin
        adc_reset_out  = 1'b0;
        dsp_reset_out  = 1'b0;
        core_reset_out = 1'b0;
        done           = 1'b1;
      end
      FAIL: fail = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected per-cycle outputs are
// queued from the documented timelines and popped as each cycle is observed.
module tb_reset_sequencer;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             soft_reset_req = 1'b0;
  logic [CNT_W-1:0] cfg_adc_dly = '0;
  logic [CNT_W-1:0] cfg_dsp_dly = '0;
  logic [CNT_W-1:0] cfg_core_dly = '0;
  logic [CNT_W-1:0] cfg_lock_timeout = '0;
  logic             adc_ready = 1'b0;
  logic             adc_reset_out, dsp_reset_out, core_reset_out, done, fail;
  logic [1:0]       fail_code;
  logic [2:0]       state_o;

  reset_sequencer #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .soft_reset_req(soft_reset_req),
    .cfg_adc_dly(cfg_adc_dly), .cfg_dsp_dly(cfg_dsp_dly),
    .cfg_core_dly(cfg_core_dly), .cfg_lock_timeout(cfg_lock_timeout),
    .adc_ready(adc_ready), .adc_reset_out(adc_reset_out),
    .dsp_reset_out(dsp_reset_out), .core_reset_out(core_reset_out),
    .done(done), .fail(fail), .fail_code(fail_code), .state_o(state_o)
  );

  always #5 clock = ~clock;

  localparam logic [2:0] S_ADC = 3'd0, S_LOCK = 3'd1, S_DSP = 3'd2,
                         S_CORE = 3'd3, S_RUN = 3'd4, S_FAIL = 3'd5;

  typedef struct {
    int         cyc;
    logic [9:0] vec;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur = 0;

  // {state[2:0], adc, dsp, core, done, fail, code[1:0]} from the output table
  function automatic logic [9:0] exp_vec(input logic [2:0] st, input logic [1:0] code);
    logic [4:0] o;
    case (st)
      S_ADC:  o = 5'b11100;
      S_LOCK: o = 5'b01100;
      S_DSP:  o = 5'b01100;
      S_CORE: o = 5'b00100;
      S_RUN:  o = 5'b00010;
      default: o = 5'b11101;
    endcase
    return {st, o, code};
  endfunction

  task automatic push_range(input int c0, input int c1, input logic [2:0] st,
                            input logic [1:0] code, input string tag);
    for (int c = c0; c <= c1; c++) begin
      exp_t e;
      e.cyc = c;
      e.vec = exp_vec(st, code);
      e.tag = tag;
      q.push_back(e);
    end
  endtask

  // Compare expectations for the current cycle, then advance one clock.
  task automatic step();
    logic [9:0] obs;
    obs = {state_o, adc_reset_out, dsp_reset_out, core_reset_out, done, fail, fail_code};
    while (q.size() > 0 && q[0].cyc == cur) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      assert (obs === e.vec) else begin
        errors++;
        $error("FAIL %s cycle %0d: got state/adc/dsp/core/done/fail/code=%b exp %b",
               e.tag, cur, obs, e.vec);
      end
    end
    @(negedge clock);
    cur++;
  endtask

  task automatic begin_scn(input int adc, input int dsp, input int core, input int tmo);
    reset = 1'b1;
    soft_reset_req = 1'b0;
    cfg_adc_dly = CNT_W'(adc);
    cfg_dsp_dly = CNT_W'(dsp);
    cfg_core_dly = CNT_W'(core);
    cfg_lock_timeout = CNT_W'(tmo);
    @(negedge clock);
    reset = 1'b0;
    cur = 0;
  endtask

  task automatic end_scn(input string tag);
    int left;
    left = q.size();
    checks++;
    assert (left === 0) else begin
      errors++;
      $error("FAIL %s leftover expectations: got %0d exp 0", tag, left);
    end
    q.delete();
  endtask

  initial begin
    // Nominal sequence, lock lost at cycle 20, soft-reset recovery.
    begin_scn(4, 3, 5, 10);
    push_range(0, 3, S_ADC, 2'b00, "nom_adc");
    push_range(4, 4, S_LOCK, 2'b00, "nom_lock");
    push_range(5, 7, S_DSP, 2'b00, "nom_dsp");
    push_range(8, 12, S_CORE, 2'b00, "nom_core");
    push_range(13, 20, S_RUN, 2'b00, "nom_run");
    push_range(21, 25, S_FAIL, 2'b10, "lost_fail");
    push_range(26, 29, S_ADC, 2'b00, "rec_adc");
    push_range(30, 30, S_LOCK, 2'b00, "rec_lock");
    push_range(31, 33, S_DSP, 2'b00, "rec_dsp");
    push_range(34, 38, S_CORE, 2'b00, "rec_core");
    push_range(39, 41, S_RUN, 2'b00, "rec_run");
    for (int c = 0; c <= 41; c++) begin
      adc_ready = (c < 20 || c >= 25);
      soft_reset_req = (c == 25);
      step();
    end
    end_scn("nominal");

    // Lock timeout: 10 cycles in LOCK_WAIT then sticky FAIL.
    begin_scn(4, 3, 5, 10);
    push_range(0, 3, S_ADC, 2'b00, "tmo_adc");
    push_range(4, 13, S_LOCK, 2'b00, "tmo_lock");
    push_range(14, 64, S_FAIL, 2'b01, "tmo_fail");
    for (int c = 0; c <= 64; c++) begin
      adc_ready = 1'b0;
      step();
    end
    end_scn("timeout");

    // Soft reset held 3 cycles during CORE_HOLD.
    begin_scn(4, 3, 5, 10);
    push_range(0, 3, S_ADC, 2'b00, "soft_adc");
    push_range(4, 4, S_LOCK, 2'b00, "soft_lock");
    push_range(5, 7, S_DSP, 2'b00, "soft_dsp");
    push_range(8, 10, S_CORE, 2'b00, "soft_core");
    push_range(11, 16, S_ADC, 2'b00, "soft_hold");
    push_range(17, 17, S_LOCK, 2'b00, "soft_lock2");
    push_range(18, 20, S_DSP, 2'b00, "soft_dsp2");
    push_range(21, 25, S_CORE, 2'b00, "soft_core2");
    push_range(26, 28, S_RUN, 2'b00, "soft_run");
    for (int c = 0; c <= 28; c++) begin
      adc_ready = 1'b1;
      soft_reset_req = (c >= 10 && c <= 12);
      step();
    end
    end_scn("soft");

    // Zero delays: one cycle per stage.
    begin_scn(0, 0, 0, 0);
    push_range(0, 0, S_ADC, 2'b00, "zero_adc");
    push_range(1, 1, S_LOCK, 2'b00, "zero_lock");
    push_range(2, 2, S_DSP, 2'b00, "zero_dsp");
    push_range(3, 3, S_CORE, 2'b00, "zero_core");
    push_range(4, 6, S_RUN, 2'b00, "zero_run");
    for (int c = 0; c <= 6; c++) begin
      adc_ready = 1'b1;
      step();
    end
    end_scn("zero");

    // Timeout 0: LOCK_WAIT waits indefinitely until adc_ready.
    begin_scn(0, 0, 0, 0);
    push_range(0, 0, S_ADC, 2'b00, "inf_adc");
    push_range(1, 41, S_LOCK, 2'b00, "inf_lock");
    push_range(42, 42, S_DSP, 2'b00, "inf_dsp");
    push_range(43, 43, S_CORE, 2'b00, "inf_core");
    push_range(44, 45, S_RUN, 2'b00, "inf_run");
    for (int c = 0; c <= 45; c++) begin
      adc_ready = (c >= 41);
      step();
    end
    end_scn("no_timeout");

    // Config change mid CORE_HOLD is ignored until next entry.
    begin_scn(4, 3, 5, 10);
    push_range(0, 3, S_ADC, 2'b00, "cfg_adc");
    push_range(4, 4, S_LOCK, 2'b00, "cfg_lock");
    push_range(5, 7, S_DSP, 2'b00, "cfg_dsp");
    push_range(8, 12, S_CORE, 2'b00, "cfg_core");
    push_range(13, 15, S_RUN, 2'b00, "cfg_run");
    for (int c = 0; c <= 15; c++) begin
      adc_ready = 1'b1;
      if (c == 9) cfg_core_dly = CNT_W'(1);
      if (c == 10) cfg_core_dly = CNT_W'(20);
      step();
    end
    end_scn("cfg_latch");

    // Synchronous reset at cycle 9 restarts the sequence.
    begin_scn(4, 3, 5, 10);
    push_range(0, 3, S_ADC, 2'b00, "rst_adc");
    push_range(4, 4, S_LOCK, 2'b00, "rst_lock");
    push_range(5, 7, S_DSP, 2'b00, "rst_dsp");
    push_range(8, 9, S_CORE, 2'b00, "rst_core");
    push_range(10, 13, S_ADC, 2'b00, "rst_adc2");
    push_range(14, 14, S_LOCK, 2'b00, "rst_lock2");
    push_range(15, 16, S_DSP, 2'b00, "rst_dsp2");
    for (int c = 0; c <= 16; c++) begin
      adc_ready = 1'b1;
      reset = (c == 9);
      step();
    end
    end_scn("sync_reset");

    // Lock loss on the last CORE_HOLD cycle wins over stage expiry.
    begin_scn(4, 3, 5, 10);
    push_range(0, 3, S_ADC, 2'b00, "pri_adc");
    push_range(4, 4, S_LOCK, 2'b00, "pri_lock");
    push_range(5, 7, S_DSP, 2'b00, "pri_dsp");
    push_range(8, 12, S_CORE, 2'b00, "pri_core");
    push_range(13, 15, S_FAIL, 2'b10, "pri_fail");
    for (int c = 0; c <= 15; c++) begin
      adc_ready = (c != 12);
      step();
    end
    end_scn("priority");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Single-clock controller that orders reset release for the mixed-signal datapath: ADC clock-generator reset, then DSP reset, then core reset.
- Each stage uses a programmable hold time.
- After the ADC reset is released, the block waits for the ADC clock-ready indication, with a timeout.
- Once running, it supervises ADC readiness and reports done/fail status to the test harness or host.

Parameters:
- CNT_W, 16, width of all delay/timeout configuration inputs and of the internal counter.

Ports:
- clock  in  1  block clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; forces the reset state below.
- soft_reset_req  in  1  level; while high, the sequence restarts from ADC_HOLD.
- cfg_adc_dly  in  CNT_W  ADC_HOLD length in cycles.
- cfg_dsp_dly  in  CNT_W  DSP_HOLD length in cycles.
- cfg_core_dly  in  CNT_W  CORE_HOLD length in cycles.
- cfg_lock_timeout  in  CNT_W  maximum LOCK_WAIT cycles; 0 = wait forever.
- adc_ready  in  1  ADC clock-ready/lock indication, already synchronous to clock.
- adc_reset_out  out  1  reset to the ADC clock generator, active-high.
- dsp_reset_out  out  1  reset to the DSP domain, active-high.
- core_reset_out  out  1  reset to the core domain, active-high.
- done  out  1  high in RUN.
- fail  out  1  high in FAIL.
- fail_code  out  2  01 = lock timeout, 10 = lock lost, 00 = none.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- States and encodings: ADC_HOLD=0, LOCK_WAIT=1, DSP_HOLD=2, CORE_HOLD=3, RUN=4, FAIL=5. All outputs are decoded from registered state (Moore).
- Reset (reset=1 at a rising edge):
  - state=ADC_HOLD, counter cleared, fail_code=00.
  - Outputs: adc/dsp/core_reset_out=1, done=0, fail=0.
- Per-state outputs:
  - ADC_HOLD: all three resets=1.
  - LOCK_WAIT: adc_reset_out=0, dsp_reset_out=1, core_reset_out=1.
  - DSP_HOLD: adc_reset_out=0, dsp_reset_out=1, core_reset_out=1.
  - CORE_HOLD: adc_reset_out=0, dsp_reset_out=0, core_reset_out=1.
  - RUN: all three resets=0, done=1.
  - FAIL: all three resets=1, fail=1.
- Stage timing:
  - Each hold state lasts exactly max(cfg_x_dly,1) cycles; a delay of 0 is treated as 1.
  - The counter loads on state entry. The config value is latched at entry, so changes mid-stage are ignored until the next entry.
- LOCK_WAIT:
  - adc_ready is sampled every cycle in the state, including the first. If high, the next state is DSP_HOLD; minimum dwell is 1 cycle.
  - If cfg_lock_timeout=N>0 and adc_ready is low for N consecutive LOCK_WAIT cycles, the next state is FAIL with fail_code=01.
  - If N=0, the block waits indefinitely.
- Lock loss: adc_ready=0 in DSP_HOLD, CORE_HOLD or RUN → next state FAIL, fail_code=10. This check has priority over stage-count expiry in the same cycle.
- FAIL is sticky; only soft_reset_req or reset leaves it.
- soft_reset_req=1 in any state:
  - Next state ADC_HOLD, counter reloaded, fail_code cleared.
  - Highest priority below reset.
  - Held high, it keeps the block in ADC_HOLD with the counter reloading every cycle; the count starts on the first cycle after it drops.
- Priority per cycle, highest first: reset, then soft_reset_req, then lock loss/timeout, then counter expiry/ready.
- Counter: CNT_W bits, down-counting; it never wraps, because it reloads on every entry.
- Cycle numbering: cycle 0 = first rising edge with reset=0. The sequence starts automatically; no start input.

Test Plan:
- Nominal: adc=4, dsp=3, core=5, timeout=10, adc_ready=1 throughout → adc_reset_out falls at cycle 4, LOCK_WAIT occupies cycle 4 only, dsp_reset_out falls at cycle 8, core_reset_out falls and done rises at cycle 13.
- Lock timeout: same config, adc_ready=0 → LOCK_WAIT cycles 4–13; FAIL at cycle 14 with fail=1, fail_code=01, all resets=1; remains in FAIL 50 further cycles.
- Lock lost: nominal run, then drop adc_ready at cycle 20 → cycle 21 FAIL, fail_code=10, all resets=1, done=0. Then soft_reset_req pulse 1 cycle → ADC_HOLD, fail_code=00, sequence completes again after 13 cycles.
- Soft reset mid-sequence: assert soft_reset_req at cycle 10 (CORE_HOLD) for 3 cycles → ADC_HOLD from cycle 11, dsp_reset_out=1; adc_reset_out falls 4 cycles after soft_reset_req drops.
- Zero delays: all cfg=0, timeout=0, adc_ready=1 → states ADC_HOLD, LOCK_WAIT, DSP_HOLD, CORE_HOLD one cycle each; RUN at cycle 4.
- Sync reset mid-operation and config change: assert reset at cycle 9 → next edge all resets=1, state_o=0. Also change cfg_core_dly during CORE_HOLD → stage length still equals the value latched at entry.
